goertzel_tone_gen: RTL

Recursive sinusoid generator that drives the Goertzel bin detector in the tone-detection path. It produces a burst of NS signed 8.24 samples of y[n] = A·sin(n·w). The recursion y[n] = alpha·y[n-1] − y[n-2] uses the same alpha = 2cos(w) coefficient format as the detector. Samples leave through a valid/ready handshake, so the detector, a FIFO or a bench can consume them at any rate.

---
 rtl/tone_pkg.sv | 37 +++
 rtl/mult_sign.sv | 20 ++
 rtl/goertzel_tone_gen.sv | 114 +++++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// Shared types and fixed-point constants for the recursive tone generator.
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned DW        = 64;
  localparam int unsigned FRAC      = 32;
  localparam int unsigned IN_SHIFT  = 12;  // 20.44 -> 32.32
  localparam int unsigned OUT_SHIFT = 8;   // 32.32 <-> 8.24 (also used for amp)

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

  // Coefficients latched on an accepted start, already in 32.32.
  typedef struct packed {
    logic signed [DW-1:0] alpha;
    logic signed [DW-1:0] sin_w;
    logic signed [DW-1:0] amp;
  } coef_t;

  // 32.32 -> 8.24 with clamping to the signed 32-bit range.
  function automatic logic [31:0] sat_824(input logic signed [DW-1:0] x);
    logic signed [55:0] v;
    v = 56'(x >>> OUT_SHIFT);
    if (v[55:31] == {25{v[55]}}) begin
      sat_824 = v[31:0];
    end else begin
      sat_824 = v[55] ? SAT_MIN : SAT_MAX;
    end
  endfunction

endpackage

// File: rtl/mult_sign.sv
// Signed fixed-point multiplier: full product realigned to the output format, truncated.
module mult_sign #(
  parameter int unsigned DW     = 64,
  parameter int unsigned INT1_I = 32,
  parameter int unsigned INT2_I = 32,
  parameter int unsigned INT3_O = 32
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] p_c
);

  localparam int unsigned SH = (DW - INT1_I) + (DW - INT2_I) - (DW - INT3_O);

  logic signed [2*DW-1:0] prod;

  assign prod = (2*DW)'(a) * (2*DW)'(b);
  assign p_c  = DW'(prod >>> SH);

endmodule

// File: rtl/goertzel_tone_gen.sv
// Burst sinusoid generator y[n] = alpha*y[n-1] - y[n-2], streamed over valid/ready.
module goertzel_tone_gen
  import tone_pkg::*;
#(
  parameter int unsigned NS = 1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [63:0] alpha_i,
  input  logic [63:0] sin_w_i,
  input  logic [31:0] amp_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned CW = (NS > 2) ? $clog2(NS) : 1;

  state_e               state;
  coef_t                coef;
  logic [CW-1:0]        cnt;
  logic signed [DW-1:0] ym1, ym2;
  logic signed [DW-1:0] op_a, op_b, prod, nxt;
  logic                 accept;

  // Single shared multiplier: B = A*sin(w) in INIT, alpha*y[n-1] in RUN.
  always_comb begin
    op_a = coef.amp;
    op_b = coef.sin_w;
    if (state == RUN) begin
      op_a = coef.alpha;
      op_b = ym1;
    end
  end

  mult_sign #(
    .DW     (DW),
    .INT1_I (DW - FRAC),
    .INT2_I (DW - FRAC),
    .INT3_O (DW - FRAC)
  ) u_mult (
    .a   (op_a),
    .b   (op_b),
    .p_c (prod)
  );

  assign nxt    = prod - ym2;
  assign accept = valid_o && ready_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      coef    <= '0;
      cnt     <= '0;
      ym1     <= '0;
      ym2     <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (stop_i) begin
        state   <= IDLE;
        valid_o <= 1'b0;
        busy_o  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              coef.alpha <= $signed(alpha_i) >>> IN_SHIFT;
              coef.sin_w <= $signed(sin_w_i) >>> IN_SHIFT;
              coef.amp   <= DW'($signed(amp_i)) <<< OUT_SHIFT;
              busy_o     <= 1'b1;
              state      <= INIT;
            end
          end
          INIT: begin
            ym2     <= '0;
            ym1     <= prod;
            data_o  <= sat_824('0);
            valid_o <= 1'b1;
            cnt     <= '0;
            state   <= RUN;
          end
          RUN: begin
            if (accept) begin
              cnt <= cnt + 1'b1;
              if (cnt == CW'(NS - 1)) begin
                valid_o <= 1'b0;
                busy_o  <= 1'b0;
                state   <= DONE;
              end else begin
                data_o <= sat_824(ym1);
                ym2    <= ym1;
                ym1    <= nxt;
              end
            end
          end
          DONE: begin
            done_o <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
